pq_ctrl: RTL and testbench
==========================

Name: pq_ctrl

Overview:
Sequencing controller for the priQueue sorted-shift-register priority queue. Arbitrates push requests from NREQ producers (round-robin) and pop requests from one consumer. Drives the queue's newVal/loadIn/shiftOut/clear pins and tracks occupancy so the queue never overflows or underflows. Provides a flush command with completion pulse and a post-reset initialisation clear.

Parameters:
DEPTH, 6, queue entries; must match the attached priQueue.
WIDTH, 1, key width in bits.
NREQ, 2, number of push requesters, 1..8.
STARVE, 4, consecutive pops allowed while a push is pending before one push slot is forced.

Ports:
ck  in  1  clock.
r  in  1  reset. One clock; reset is synchronous and active-high.
push_req  in  NREQ  per-requester push request; level, held until granted.
push_data  in  NREQ*WIDTH  per-requester key; requester i occupies bits [i*WIDTH +: WIDTH].
push_gnt  out  NREQ  one-hot grant; data is taken in the cycle the grant is high.
pop_req  in  1  consumer pop request; level.
pop_valid  out  1  registered; one-cycle pulse carrying the popped key.
pop_data  out  WIDTH  registered popped key; holds its value between pops.
flush_req  in  1  request to empty the queue; level.
flush_done  out  1  one-cycle pulse when the flush completes.
pq_newVal  out  WIDTH  to priQueue newVal.
pq_loadIn  out  1  to priQueue loadIn.
pq_shiftOut  out  1  to priQueue shiftOut.
pq_clear  out  1  to priQueue clear.
pq_top  in  WIDTH  from priQueue top (current maximum).
count  out  $clog2(DEPTH+1)  registered occupancy.
full  out  1  count==DEPTH.
empty  out  1  count==0.

Behaviour:
- FSM states: INIT, RUN, FLUSH, DONE.
- Reset (r=1 at a ck edge): state=INIT, count=0, pop_valid=0, pop_data=0, flush_done=0, round-robin pointer=0, starve counter=0. All pq_* outputs and push_gnt are 0 while r=1.
- INIT: pq_clear=1 for exactly one cycle, then RUN. No grants.
- RUN, per cycle, the controller issues at most one queue operation: pq_loadIn and pq_shiftOut are never high together.
  - Pop is eligible when pop_req=1 and count>0.
  - Push is eligible when any push_req=1 and count<DEPTH.
  - If both are eligible, pop wins, unless starve counter==STARVE. In that case push wins and the starve counter clears.
  - Starve counter: increments on each pop granted while a push is eligible; clears on any push; saturates at STARVE.
- Pop cycle:
  - pq_shiftOut=1.
  - pop_data<=pq_top and pop_valid<=1 at the next edge. Latency from grant to pop_valid is 1 cycle.
  - count decrements.
- Push cycle:
  - Round-robin arbiter picks the first requester at or after the pointer.
  - push_gnt[i]=1 combinationally in the same cycle, with pq_newVal=push_data[i] and pq_loadIn=1.
  - count increments; pointer<=i+1, wrapping modulo NREQ.
- Neither eligible: all queue strobes are 0 and pq_newVal=0.
- Boundaries:
  - pop_req while empty: ignored; no pop_valid, no strobe.
  - push_req while full: no grant.
  - pop and push eligible at full: pop wins even if starved, since push is not eligible.
- flush_req sampled in RUN:
  - Takes priority over push and pop in the same cycle; no grant or strobe is issued that cycle.
  - Next state is FLUSH.
- FLUSH: pq_clear=1 for one cycle; count<=0; next state DONE.
- DONE: flush_done=1 for one cycle; next state RUN. A still-asserted flush_req is re-sampled only once back in RUN.
- A pop issued in the cycle flush_req is first seen is suppressed; only pops issued earlier deliver pop_valid.
- Reset mid-operation (any state) returns to INIT; in-flight pop_valid is dropped.
- count updates on the same edge as the strobe; full and empty are decoded from registered count.

Decomposition:
- Shared package pq_pkg:
  - state enum {INIT, RUN, FLUSH, DONE};
  - DEPTH and WIDTH defaults;
  - count-width function $clog2(DEPTH+1).
- One sub-module: pq_rr_arb (NREQ-way round-robin arbiter: req, pointer, enable -> one-hot gnt and index). Everything else stays inline in pq_ctrl.

Test Plan:
- Reset then idle:
  - after r drops, pq_clear=1 for exactly one cycle (INIT), then 0;
  - count=0, empty=1, no grants.
- Sort order (WIDTH=4):
  - requester 0 pushes 3, 9, 5 on consecutive cycles; then hold pop_req for 3 cycles;
  - pop_data sequence is 9, 5, 3, each with pop_valid 1 cycle after its shiftOut; count returns to 0.
- Full/empty bounds:
  - push 6 keys; 7th push_req gets no grant while full=1;
  - then pop 7 times: 6 pop_valid pulses, the 7th is ignored, empty=1.
- Round-robin:
  - both requesters hold push_req with data 1 and 2;
  - grants alternate req0, req1, req0, …; at most one grant per cycle.
- Starvation (STARVE=4):
  - queue holds 5 entries, pop_req and push_req held;
  - after 4 pops, the next cycle is a push grant, then pops resume.
- Flush:
  - with count=4, assert flush_req together with pop_req;
  - no pop that cycle; pq_clear=1 next cycle; flush_done the cycle after; count=0; RUN resumes.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and sizing helpers for the priority-queue controller.
package pq_pkg;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StFlush,
        StDone
    } pq_state_e;

    localparam int unsigned DefDepth = 6;
    localparam int unsigned DefWidth = 1;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module pq_rr_arb #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PtrW-1:0] i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [PtrW-1:0] o_idx
);

    logic            w_hi_found;
    logic            w_any_found;
    logic [PtrW-1:0] w_hi_idx;
    logic [PtrW-1:0] w_any_idx;

    // Lowest requester at/after the pointer, plus lowest overall as the wrap fallback.
    always_comb begin
        w_hi_found  = 1'b0;
        w_any_found = 1'b0;
        w_hi_idx    = '0;
        w_any_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_any_found = 1'b1;
                w_any_idx   = PtrW'(i);
                if (i >= int'(i_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = PtrW'(i);
                end
            end
        end
    end

    assign o_idx = w_hi_found ? w_hi_idx : w_any_idx;

    // One-hot grant, only when the controller actually issues a push.
    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_gnt[i] = i_en && w_any_found && (o_idx == PtrW'(i));
        end
    end

endmodule

// File: rtl/pq_ctrl.sv
// Sequencing controller for the priQueue sorted shift register: push/pop arbitration,
// occupancy tracking, flush and post-reset clear.
module pq_ctrl
    import pq_pkg::*;
#(
    parameter int unsigned DEPTH  = DefDepth,
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NREQ   = 2,
    parameter int unsigned STARVE = 4
) (
    input  logic                        ck,
    input  logic                        r,
    input  logic [NREQ-1:0]             push_req,
    input  logic [NREQ*WIDTH-1:0]       push_data,
    output logic [NREQ-1:0]             push_gnt,
    input  logic                        pop_req,
    output logic                        pop_valid,
    output logic [WIDTH-1:0]            pop_data,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic [WIDTH-1:0]            pq_newVal,
    output logic                        pq_loadIn,
    output logic                        pq_shiftOut,
    output logic                        pq_clear,
    input  logic [WIDTH-1:0]            pq_top,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned StvW = $clog2(STARVE + 1);

    pq_state_e       r_state;
    pq_state_e       w_state_d;
    logic [CntW-1:0] r_count;
    logic [PtrW-1:0] r_ptr;
    logic [StvW-1:0] r_starve;
    logic            r_pop_valid;
    logic [WIDTH-1:0] r_pop_data;

    logic            w_pop_elig;
    logic            w_push_elig;
    logic            w_starved;
    logic            w_do_pop;
    logic            w_do_push;
    logic            w_clear;
    logic [NREQ-1:0] w_gnt;
    logic [PtrW-1:0] w_idx;
    logic [PtrW-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_new_val;

    assign w_pop_elig  = pop_req && (r_count != '0);
    assign w_push_elig = (|push_req) && (r_count != CntW'(DEPTH));
    assign w_starved   = (r_starve == StvW'(STARVE));

    pq_rr_arb #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_arb (
        .i_req (push_req),
        .i_ptr (r_ptr),
        .i_en  (w_do_push),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_ptr_next = (int'(w_idx) == int'(NREQ) - 1) ? '0 : w_idx + PtrW'(1);

    // Next state and per-cycle queue operation; everything is held off while r is high.
    always_comb begin
        w_state_d = r_state;
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        w_clear   = 1'b0;
        if (!r) begin
            unique case (r_state)
                StInit: begin
                    w_clear   = 1'b1;
                    w_state_d = StRun;
                end
                StRun: begin
                    if (flush_req) begin
                        w_state_d = StFlush;
                    end else if (w_pop_elig && !(w_push_elig && w_starved)) begin
                        w_do_pop = 1'b1;
                    end else if (w_push_elig) begin
                        w_do_push = 1'b1;
                    end
                end
                StFlush: begin
                    w_clear   = 1'b1;
                    w_state_d = StDone;
                end
                StDone: begin
                    w_state_d = StRun;
                end
                default: begin
                    w_state_d = StInit;
                end
            endcase
        end
    end

    // Select the granted requester's key for the queue input; zero when nothing is granted.
    always_comb begin
        w_new_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_new_val = push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // State, occupancy, arbitration pointer, starvation counter and pop result registers.
    always_ff @(posedge ck) begin
        if (r) begin
            r_state     <= StInit;
            r_count     <= '0;
            r_ptr       <= '0;
            r_starve    <= '0;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_pop_valid <= w_do_pop;
            if (w_do_pop) begin
                r_pop_data <= pq_top;
            end
            if (r_state == StFlush) begin
                r_count <= '0;
            end else if (w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end else if (w_do_push) begin
                r_count <= r_count + CntW'(1);
            end
            if (w_do_push) begin
                r_ptr    <= w_ptr_next;
                r_starve <= '0;
            end else if (w_do_pop && w_push_elig && !w_starved) begin
                r_starve <= r_starve + StvW'(1);
            end
        end
    end

    assign push_gnt    = w_gnt;
    assign pq_newVal   = w_new_val;
    assign pq_loadIn   = w_do_push;
    assign pq_shiftOut = w_do_pop;
    assign pq_clear    = w_clear;
    assign pop_valid   = r_pop_valid;
    assign pop_data    = r_pop_data;
    assign flush_done  = (r_state == StDone);
    assign count       = r_count;
    assign full        = (r_count == CntW'(DEPTH));
    assign empty       = (r_count == '0);

endmodule

// File: tb/tb_pq_ctrl.sv
// Self-checking bench for pq_ctrl with a behavioural priQueue model and a pop scoreboard.
module tb_pq_ctrl;

    logic       ck = 1'b0;
    logic       r = 1'b1;
    logic [1:0] push_req = '0;
    logic [7:0] push_data = '0;
    logic [1:0] push_gnt;
    logic       pop_req = 1'b0;
    logic       pop_valid;
    logic [3:0] pop_data;
    logic       flush_req = 1'b0;
    logic       flush_done;
    logic [3:0] pq_newVal;
    logic       pq_loadIn;
    logic       pq_shiftOut;
    logic       pq_clear;
    logic [3:0] pq_top;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Behavioural priQueue: descending sorted array, top is the maximum.
    logic [3:0] mq [6];
    logic [3:0] tmp [6];
    int mn = 0;
    int pos;

    pq_ctrl #(
        .DEPTH  (6),
        .WIDTH  (4),
        .NREQ   (2),
        .STARVE (4)
    ) dut (
        .ck          (ck),
        .r           (r),
        .push_req    (push_req),
        .push_data   (push_data),
        .push_gnt    (push_gnt),
        .pop_req     (pop_req),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .pq_newVal   (pq_newVal),
        .pq_loadIn   (pq_loadIn),
        .pq_shiftOut (pq_shiftOut),
        .pq_clear    (pq_clear),
        .pq_top      (pq_top),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    assign pq_top = (mn > 0) ? mq[0] : 4'd0;

    always @(posedge ck) begin
        if (pq_clear) begin
            mn <= 0;
        end else if (pq_shiftOut && mn > 0) begin
            for (int i = 0; i < 5; i++) mq[i] <= mq[i+1];
            mn <= mn - 1;
        end else if (pq_loadIn && mn < 6) begin
            pos = 0;
            while (pos < mn && mq[pos] >= pq_newVal) pos++;
            for (int i = 0; i < 6; i++) tmp[i] = mq[i];
            for (int i = 5; i > pos; i--) tmp[i] = mq[i-1];
            tmp[pos] = pq_newVal;
            for (int i = 0; i < 6; i++) mq[i] <= tmp[i];
            mn <= mn + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop monitor: every pop_valid must match the oldest expected key, one cycle after issue.
    always @(negedge ck) begin
        exp_t e;
        n_checks++;
        if ((pq_loadIn && pq_shiftOut) || ($countones(push_gnt) > 1)) begin
            n_fail++;
            $display("FAIL strobe_excl: loadIn=%0d shiftOut=%0d gnt=%b", pq_loadIn, pq_shiftOut,
                     push_gnt);
        end
        if (pop_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pop_data %0d, expected no pop_valid", pop_data);
            end else begin
                e = sb.pop_front();
                check("pop_data", 32'(pop_data), 32'(e.data));
                check("pop_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end
    end

    task automatic expect_pop(input logic [3:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] preq, input logic [7:0] pdat, input logic pop,
                         input logic fl);
        @(negedge ck);
        push_req  = preq;
        push_data = pdat;
        pop_req   = pop;
        flush_req = fl;
        #1;
    endtask

    task automatic push_step(input logic [1:0] preq, input logic [7:0] pdat,
                             input logic [1:0] egnt, input logic [3:0] eval);
        drive(preq, pdat, 1'b0, 1'b0);
        check("push_gnt", 32'(push_gnt), 32'(egnt));
        check("push_newVal", 32'(pq_newVal), 32'(eval));
        check("push_loadIn", 32'(pq_loadIn), 1);
    endtask

    task automatic pop_step(input logic [1:0] preq, input logic [7:0] pdat,
                            input logic [3:0] eval, input int ecnt);
        drive(preq, pdat, 1'b1, 1'b0);
        check("pop_count", 32'(count), 32'(ecnt));
        check("pop_shiftOut", 32'(pq_shiftOut), 1);
        check("pop_no_gnt", 32'(push_gnt), 0);
        expect_pop(eval);
    endtask

    task automatic do_reset();
        @(negedge ck);
        r = 1'b1;
        push_req = 2'b11;
        push_data = 8'h21;
        pop_req = 1'b1;
        flush_req = 1'b0;
        #1;
        check("rst_gnt", 32'(push_gnt), 0);
        check("rst_strobes", 32'({pq_loadIn, pq_shiftOut, pq_clear}), 0);
        @(negedge ck);
        check("rst_pop_valid", 32'(pop_valid), 0);
        r = 1'b0;
        push_req = '0;
        push_data = '0;
        pop_req = 1'b0;
        #1;
        check("init_clear", 32'(pq_clear), 1);
        check("init_gnt", 32'(push_gnt), 0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        check("init_clear_once", 32'(pq_clear), 0);
        check("init_count", 32'(count), 0);
        check("init_empty", 32'(empty), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Sort order.
        push_step(2'b01, 8'h03, 2'b01, 4'd3);
        push_step(2'b01, 8'h09, 2'b01, 4'd9);
        push_step(2'b01, 8'h05, 2'b01, 4'd5);
        pop_step(2'b00, 8'h00, 4'd9, 3);
        pop_step(2'b00, 8'h00, 4'd5, 2);
        pop_step(2'b00, 8'h00, 4'd3, 1);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        check("sort_count", 32'(count), 0);
        check("sort_empty", 32'(empty), 1);
        check("pop_data_hold", 32'(pop_data), 3);

        // Full/empty bounds.
        push_step(2'b01, 8'h04, 2'b01, 4'd4);
        push_step(2'b01, 8'h07, 2'b01, 4'd7);
        push_step(2'b01, 8'h02, 2'b01, 4'd2);
        push_step(2'b01, 8'h08, 2'b01, 4'd8);
        push_step(2'b01, 8'h01, 2'b01, 4'd1);
        push_step(2'b01, 8'h06, 2'b01, 4'd6);
        drive(2'b01, 8'h03, 1'b0, 1'b0);
        check("full_flag", 32'(full), 1);
        check("full_count", 32'(count), 6);
        check("full_no_gnt", 32'(push_gnt), 0);
        check("full_no_load", 32'(pq_loadIn), 0);
        pop_step(2'b00, 8'h00, 4'd8, 6);
        pop_step(2'b00, 8'h00, 4'd7, 5);
        pop_step(2'b00, 8'h00, 4'd6, 4);
        pop_step(2'b00, 8'h00, 4'd4, 3);
        pop_step(2'b00, 8'h00, 4'd2, 2);
        pop_step(2'b00, 8'h00, 4'd1, 1);
        drive(2'b00, 8'h00, 1'b1, 1'b0);
        check("empty_pop_ignored", 32'(pq_shiftOut), 0);
        check("empty_flag", 32'(empty), 1);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);

        // Round-robin from a fresh pointer.
        do_reset();
        push_step(2'b11, 8'h21, 2'b01, 4'd1);
        push_step(2'b11, 8'h21, 2'b10, 4'd2);
        push_step(2'b11, 8'h21, 2'b01, 4'd1);
        push_step(2'b11, 8'h21, 2'b10, 4'd2);
        push_step(2'b11, 8'h21, 2'b01, 4'd1);

        // Starvation: four pops, then a forced push, then pops resume.
        pop_step(2'b11, 8'h21, 4'd2, 5);
        pop_step(2'b11, 8'h21, 4'd2, 4);
        pop_step(2'b11, 8'h21, 4'd1, 3);
        pop_step(2'b11, 8'h21, 4'd1, 2);
        drive(2'b11, 8'h21, 1'b1, 1'b0);
        check("starve_push_gnt", 32'(push_gnt), 32'(2'b10));
        check("starve_newVal", 32'(pq_newVal), 2);
        check("starve_no_pop", 32'(pq_shiftOut), 0);
        pop_step(2'b11, 8'h21, 4'd2, 2);

        // Flush with count=4 and a simultaneous pop request.
        push_step(2'b01, 8'h07, 2'b01, 4'd7);
        push_step(2'b01, 8'h03, 2'b01, 4'd3);
        push_step(2'b01, 8'h05, 2'b01, 4'd5);
        drive(2'b00, 8'h00, 1'b1, 1'b1);
        check("flush_count", 32'(count), 4);
        check("flush_no_pop", 32'(pq_shiftOut), 0);
        check("flush_no_clear_yet", 32'(pq_clear), 0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        check("flush_clear", 32'(pq_clear), 1);
        check("flush_done_early", 32'(flush_done), 0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        check("flush_done", 32'(flush_done), 1);
        check("flush_cleared_count", 32'(count), 0);
        check("flush_clear_once", 32'(pq_clear), 0);
        push_step(2'b01, 8'h06, 2'b01, 4'd6);
        check("flush_done_once", 32'(flush_done), 0);
        pop_step(2'b00, 8'h00, 4'd6, 1);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        check("final_empty", 32'(empty), 1);
        check("pending_pops", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
